// File: rtl/sdp_bram_arbiter_pkg.sv
// rtl/sdp_bram_arbiter_pkg.sv - shared constants and types for the SDP BRAM arbiter
// Purpose: BRAM geometry, arbiter burst counter width and the client-index type.
// Ports: none (package).
package sdp_bram_pkg;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 75;
  localparam int BURST_W = 4;

  // Index of one of the two clients sharing a channel.
  typedef logic client_t;

endpackage

// File: rtl/sdp_bram_arbiter_if.sv
// rtl/sdp_bram_arbiter_if.sv - client-side bus of the SDP BRAM arbiter
// Purpose: bundles the two write clients and two read clients into one bus.
// Ports (signals):
//   wr_req[1:0], wr_addr0/1, wr_data0/1 : write requests, held stable until granted
//   wr_gnt[1:0]                         : write grant, one-hot or zero
//   rd_req[1:0], rd_addr0/1             : read requests, held stable until granted
//   rd_gnt[1:0]                         : read grant, one-hot or zero
//   rd_rvalid[1:0], rd_rdata            : read response strobe per client, shared data
// Modports: master = client side, slave = arbiter side.
interface sdp_bram_arbiter_if #(
  parameter int ADDR_W = sdp_bram_pkg::ADDR_W,
  parameter int DATA_W = sdp_bram_pkg::DATA_W
);

  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_gnt;

  logic [1:0]        rd_req;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [1:0]        rd_gnt;
  logic [1:0]        rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req, rd_addr0, rd_addr1,
    input  wr_gnt, rd_gnt, rd_rvalid, rd_rdata
  );

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req, rd_addr0, rd_addr1,
    output wr_gnt, rd_gnt, rd_rvalid, rd_rdata
  );

endinterface

// File: rtl/sdp_bram_arbiter_arb.sv
// rtl/sdp_bram_arbiter_arb.sv - two-client round-robin arbiter with bounded burst lock
// Purpose: grants one of two requesters per cycle; the current owner keeps the
//   grant until the other client is waiting and MAX_BURST grants have been used.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request per client
//   gnt[1:0]  : combinational grant, one-hot or zero, zero during reset
module rr_burst_arb2
  import sdp_bram_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  client_t            owner;
  client_t            other;
  logic [BURST_W-1:0] burst_cnt;
  // Set by reset, cleared by the first grant. While set, a contested request
  // goes to the non-owner so that client 0 wins the first tie out of reset
  // even though owner resets to 1.
  logic               fresh;
  logic               keep;

  assign other = ~owner;

  always_comb begin
    gnt  = 2'b00;
    keep = req[owner] && (!req[other] || (burst_cnt < MAX_CNT))
           && !(fresh && req[other]);
    if (!rst) begin
      if (keep) begin
        gnt[owner] = 1'b1;
      end else if (req[other]) begin
        gnt[other] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= 1'b1;
      burst_cnt <= '0;
      fresh     <= 1'b1;
    end else if (gnt[owner]) begin
      burst_cnt <= (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
      fresh     <= 1'b0;
    end else if (gnt[other]) begin
      owner     <= other;
      burst_cnt <= BURST_W'(1);
      fresh     <= 1'b0;
    end else begin
      // An idle cycle ends the burst.
      burst_cnt <= '0;
    end
  end

endmodule

// File: rtl/sdp_bram_arbiter.sv
// rtl/sdp_bram_arbiter.sv - shares one simple-dual-port BRAM between two writers and two readers
// Purpose: independent round-robin/burst arbitration of the write port (A) and
//   the read port (B), address/data muxing and the per-client read-valid strobe.
// Ports:
//   clk, rst        : single clock (also BRAM clka/clkb), synchronous active-high reset
//   bus             : client bus (slave side), see sdp_bram_arbiter_if
//   bram_addra/dina/wea : BRAM write port, zero when no write is granted
//   bram_rstb       : BRAM output reset, follows rst
//   bram_addrb      : BRAM read address, zero when no read is granted
//   bram_doutb      : BRAM read data, returned as bus.rd_rdata one cycle after grant
module sdp_bram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 75,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  sdp_bram_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_wea,
  output logic              bram_rstb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic [1:0] rvalid_q;

  rr_burst_arb2 #(.MAX_BURST(MAX_BURST)) u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.wr_req),
    .gnt (wr_gnt)
  );

  rr_burst_arb2 #(.MAX_BURST(MAX_BURST)) u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.rd_req),
    .gnt (rd_gnt)
  );

  assign bus.wr_gnt = wr_gnt;
  assign bus.rd_gnt = rd_gnt;

  always_comb begin
    bram_addra = '0;
    bram_dina  = '0;
    if (wr_gnt[0]) begin
      bram_addra = bus.wr_addr0;
      bram_dina  = bus.wr_data0;
    end else if (wr_gnt[1]) begin
      bram_addra = bus.wr_addr1;
      bram_dina  = bus.wr_data1;
    end
  end

  assign bram_wea = |wr_gnt;

  always_comb begin
    bram_addrb = '0;
    if (rd_gnt[0]) begin
      bram_addrb = bus.rd_addr0;
    end else if (rd_gnt[1]) begin
      bram_addrb = bus.rd_addr1;
    end
  end

  // The BRAM registers addrb, so data appears one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 2'b00;
    end else begin
      rvalid_q <= rd_gnt;
    end
  end

  // Masked by rst so a read granted just before reset never reports valid
  // while reset is held.
  assign bus.rd_rvalid = rvalid_q & {2{~rst}};
  assign bus.rd_rdata  = bram_doutb;
  assign bram_rstb     = rst;

endmodule
